// File: rtl/imem_dmem_port_arbiter_if.sv
// CPU instruction/data SRAM ports plus the shared physical memory port.
// The arbiter sits on the slave side; the CPU and memory side uses master.
interface imem_dmem_port_arbiter_if;
  logic [31:0] cpu_inst_addr;
  logic [31:0] cpu_inst_rdata;
  logic        cpu_data_en;
  logic [3:0]  cpu_data_wen;
  logic [31:0] cpu_data_addr;
  logic [31:0] cpu_data_wdata;
  logic [31:0] cpu_data_rdata;
  logic        req_inst;
  logic        req_data;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_inst_addr, cpu_data_en, cpu_data_wen, cpu_data_addr, cpu_data_wdata, mem_rdata,
    output cpu_inst_rdata, cpu_data_rdata, req_inst, req_data,
    output mem_en, mem_wen, mem_addr, mem_wdata
  );

  modport master (
    output cpu_inst_addr, cpu_data_en, cpu_data_wen, cpu_data_addr, cpu_data_wdata, mem_rdata,
    input  cpu_inst_rdata, cpu_data_rdata, req_inst, req_data,
    input  mem_en, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_dmem_port_arbiter.sv
// Shares one single-port, 1-cycle-latency SRAM between instruction fetch and data access.
// Data wins; a data access costs one req_data cycle followed by one req_inst refetch cycle.
module imem_dmem_port_arbiter #(
  parameter logic [31:0] ADDR_MASK = 32'h1FFF_FFFF,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  imem_dmem_port_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]         perf_fetch_cnt,
  output logic [CNT_W-1:0]         perf_data_cnt,
  output logic [CNT_W-1:0]         perf_stall_cnt
);

  typedef enum logic [1:0] {StBoot, StFetch, StDresp} state_e;

  state_e      state_q;
  logic        prev_fetch_q;
  logic [31:0] inst_hold_q;
  logic [31:0] data_hold_q;
  logic        fetch_issue;
  logic        data_issue;
  logic        stall;

  always_comb begin
    fetch_issue        = 1'b0;
    data_issue         = 1'b0;
    bus.mem_en         = 1'b0;
    bus.mem_wen        = 4'b0000;
    bus.mem_addr       = bus.cpu_inst_addr & ADDR_MASK;
    bus.mem_wdata      = bus.cpu_data_wdata;
    bus.req_inst       = 1'b1;
    bus.req_data       = 1'b0;
    bus.cpu_inst_rdata = '0;
    bus.cpu_data_rdata = '0;
    if (resetn) begin
      unique case (state_q)
        StBoot:  fetch_issue = 1'b1;
        StFetch: begin
          bus.req_inst = ~prev_fetch_q;
          data_issue   = bus.cpu_data_en;
          fetch_issue  = ~bus.cpu_data_en;
        end
        // cpu_data_en still shows the access being retired here
        StDresp: fetch_issue = 1'b1;
        default: fetch_issue = 1'b0;
      endcase
      bus.mem_en   = fetch_issue | data_issue;
      bus.req_data = data_issue;
      if (data_issue) begin
        bus.mem_wen  = bus.cpu_data_wen;
        bus.mem_addr = bus.cpu_data_addr & ADDR_MASK;
      end
      bus.cpu_inst_rdata = prev_fetch_q ? bus.mem_rdata : inst_hold_q;
      bus.cpu_data_rdata = (state_q == StDresp) ? bus.mem_rdata : data_hold_q;
    end
  end

  assign stall = bus.req_inst | bus.req_data;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= StBoot;
      prev_fetch_q   <= 1'b0;
      inst_hold_q    <= '0;
      data_hold_q    <= '0;
      perf_fetch_cnt <= '0;
      perf_data_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      prev_fetch_q <= fetch_issue;
      if (prev_fetch_q) inst_hold_q <= bus.mem_rdata;
      if (state_q == StDresp) data_hold_q <= bus.mem_rdata;
      unique case (state_q)
        StBoot:  state_q <= StFetch;
        StFetch: state_q <= data_issue ? StDresp : StFetch;
        StDresp: state_q <= StFetch;
        default: state_q <= StBoot;
      endcase
      perf_fetch_cnt <= perf_fetch_cnt + CNT_W'(fetch_issue);
      perf_data_cnt  <= perf_data_cnt + CNT_W'(data_issue);
      perf_stall_cnt <= perf_stall_cnt + CNT_W'(stall);
    end
  end

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Randomized scoreboard bench for imem_dmem_port_arbiter: a cycle-level reference of the
// fetch/data schedule pushes expectations; a negedge monitor pops and compares them.
module tb_imem_dmem_port_arbiter;
  localparam logic [31:0] MASK = 32'h1FFF_FFFF;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  imem_dmem_port_arbiter_if bus ();
  imem_dmem_port_arbiter_if bus4 ();
  logic [31:0] pf, pd, ps;
  logic [3:0]  pf4, pd4, ps4;

  imem_dmem_port_arbiter #(.ADDR_MASK(MASK), .CNT_W(32)) dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .perf_fetch_cnt(pf), .perf_data_cnt(pd), .perf_stall_cnt(ps)
  );

  // Narrow-counter copy fed with the same CPU stimulus to exercise wrap-around.
  imem_dmem_port_arbiter #(.ADDR_MASK(MASK), .CNT_W(4)) dut4 (
    .clk(clk), .resetn(resetn), .bus(bus4),
    .perf_fetch_cnt(pf4), .perf_data_cnt(pd4), .perf_stall_cnt(ps4)
  );
  assign bus4.cpu_inst_addr  = bus.cpu_inst_addr;
  assign bus4.cpu_data_en    = bus.cpu_data_en;
  assign bus4.cpu_data_wen   = bus.cpu_data_wen;
  assign bus4.cpu_data_addr  = bus.cpu_data_addr;
  assign bus4.cpu_data_wdata = bus.cpu_data_wdata;
  assign bus4.mem_rdata      = bus.mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[17:2]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Physical SRAM (environment) and the bench's reference copy of its contents.
  logic [31:0] sram [int unsigned];
  logic [31:0] ref_mem [int unsigned];

  function automatic logic [31:0] sram_rd(input logic [31:0] a);
    return sram.exists(a >> 2) ? sram[a >> 2] : init_word(a & ~32'h3);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : init_word(a & ~32'h3);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) begin
      bus.mem_rdata <= sram_rd(bus.mem_addr);
      if (bus.mem_wen != 4'b0000)
        sram[bus.mem_addr >> 2] = merge(sram_rd(bus.mem_addr), bus.mem_wdata, bus.mem_wen);
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic        rinst;
    logic        rdata;
  } issue_t;

  typedef struct {
    bit          chk;
    logic [31:0] val;
  } dexp_t;

  issue_t      q_issue[$];
  logic [31:0] q_inst[$];
  dexp_t       q_data[$];

  // Reference schedule state.
  logic [31:0] pc;
  bit          jumps;
  bit          m_boot, m_resp, m_prev_fetch, m_pend_load;
  logic [31:0] m_prev_word, m_pend_val;
  logic [31:0] m_fetch, m_data, m_stall;

  task automatic model_reset();
    m_boot = 1; m_resp = 0; m_prev_fetch = 0; m_pend_load = 0;
    m_fetch = 0; m_data = 0; m_stall = 0;
  endtask

  task automatic cyc(input bit den, input logic [3:0] wen, input logic [31:0] daddr,
                     input logic [31:0] wdata);
    issue_t e;
    dexp_t  d;
    bit     is_data;
    bus.cpu_inst_addr  = pc;
    bus.cpu_data_en    = den;
    bus.cpu_data_wen   = wen;
    bus.cpu_data_addr  = daddr;
    bus.cpu_data_wdata = wdata;
    is_data = den && !m_boot && !m_resp;
    e.rinst = !m_prev_fetch;
    e.rdata = is_data;
    e.addr  = is_data ? (daddr & MASK) : (pc & MASK);
    e.wen   = is_data ? wen : 4'b0000;
    e.wdata = wdata;
    q_issue.push_back(e);
    if (m_prev_fetch) q_inst.push_back(m_prev_word);
    if (m_resp) begin
      d.chk = m_pend_load;
      d.val = m_pend_val;
      q_data.push_back(d);
    end
    if (is_data) m_data++; else m_fetch++;
    if (e.rinst || e.rdata) m_stall++;
    if (is_data) begin
      m_pend_load = (wen == 4'b0000);
      m_pend_val  = ref_rd(e.addr);
      if (wen != 4'b0000) ref_mem[e.addr >> 2] = merge(ref_rd(e.addr), wdata, wen);
    end else begin
      m_prev_word = ref_rd(e.addr);
      pc = (jumps && $urandom_range(0, 7) == 0) ?
           (32'hBFC0_0000 | (32'($urandom_range(0, 63)) << 2)) : pc + 32'd4;
    end
    m_prev_fetch = !is_data;
    m_resp       = is_data;
    m_boot       = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom);
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    bus.cpu_data_en = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    chk("rst_fetch_cnt", pf, 32'd0);
    chk("rst_data_cnt", pd, 32'd0);
    chk("rst_stall_cnt", ps, 32'd0);
    chk("rst_fetch_cnt4", 32'(pf4), 32'd0);
    for (int i = 1; i < n; i++) begin
      @(posedge clk);
      #1;
    end
    model_reset();
    resetn = 1'b1;
  endtask

  task automatic access(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd,
                        input bit abort);
    bit issued;
    issued = 0;
    while (!issued) begin
      issued = !m_boot && !m_resp;
      cyc(1'b1, wen, a, wd);
    end
    if (abort) do_reset(2);
    else cyc(1'b1, wen, a, wd);
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_fetch_cnt"}, pf, m_fetch);
    chk({tag, "_data_cnt"}, pd, m_data);
    chk({tag, "_stall_cnt"}, ps, m_stall);
    chk({tag, "_fetch_cnt4"}, 32'(pf4), 32'(m_fetch[3:0]));
    chk({tag, "_data_cnt4"}, 32'(pd4), 32'(m_data[3:0]));
    chk({tag, "_stall_cnt4"}, 32'(ps4), 32'(m_stall[3:0]));
  endtask

  function automatic logic [31:0] rand_daddr();
    logic [31:0] seg;
    seg = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'hA000_0000;
    return seg | (32'($urandom_range(0, 15)) << 2);
  endfunction

  // Monitor: consumes expectations whenever the DUT presents an access or a delivery.
  initial begin : monitor
    issue_t      e;
    dexp_t       d;
    bit          prev_rd;
    bit          hold_ok;
    logic [31:0] hold_exp, inst_exp;
    prev_rd = 0; hold_ok = 1; hold_exp = '0; inst_exp = '0;
    forever begin
      @(negedge clk);
      if (resetn !== 1'b1) begin
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_mem_wen", 32'(bus.mem_wen), 32'd0);
        chk("rst_req_inst", 32'(bus.req_inst), 32'd1);
        chk("rst_req_data", 32'(bus.req_data), 32'd0);
        chk("rst_inst_rdata", bus.cpu_inst_rdata, 32'd0);
        chk("rst_data_rdata", bus.cpu_data_rdata, 32'd0);
        prev_rd = 0; hold_ok = 1; hold_exp = '0; inst_exp = '0;
      end else begin
        if (bus.mem_en !== 1'b1 || q_issue.size() == 0) begin
          chk("issue_present", 32'(bus.mem_en), 32'(q_issue.size() != 0));
        end else begin
          e = q_issue.pop_front();
          chk("mem_addr", bus.mem_addr, e.addr);
          chk("mem_wen", 32'(bus.mem_wen), 32'(e.wen));
          chk("req_inst", 32'(bus.req_inst), 32'(e.rinst));
          chk("req_data", 32'(bus.req_data), 32'(e.rdata));
          if (e.wen != 4'b0000) chk("mem_wdata", bus.mem_wdata, e.wdata);
        end
        if (bus.req_inst === 1'b0) begin
          if (q_inst.size() == 0) begin
            chk("inst_delivery_expected", 32'(bus.req_inst), 32'd1);
          end else begin
            inst_exp = q_inst.pop_front();
            chk("inst_rdata", bus.cpu_inst_rdata, inst_exp);
          end
        end else begin
          chk("inst_rdata_hold", bus.cpu_inst_rdata, inst_exp);
        end
        if (prev_rd) begin
          if (q_data.size() == 0) begin
            chk("data_resp_expected", 32'(prev_rd), 32'd0);
          end else begin
            d = q_data.pop_front();
            if (d.chk) chk("load_rdata", bus.cpu_data_rdata, d.val);
            hold_ok  = d.chk;
            hold_exp = d.val;
          end
        end else if (hold_ok) begin
          chk("data_rdata_hold", bus.cpu_data_rdata, hold_exp);
        end
        prev_rd = (bus.req_data === 1'b1);
      end
    end
  end

  initial begin : stim
    int r;
    resetn = 1'b0;
    bus.cpu_inst_addr = 32'hBFC0_0000;
    bus.cpu_data_en = 1'b0; bus.cpu_data_wen = '0;
    bus.cpu_data_addr = '0; bus.cpu_data_wdata = '0;
    bus.mem_rdata = '0;
    sram[32'h10 >> 2] = 32'hDEAD_BEEF; ref_mem[32'h10 >> 2] = 32'hDEAD_BEEF;
    sram[32'h20 >> 2] = 32'hAABB_CCDD; ref_mem[32'h20 >> 2] = 32'hAABB_CCDD;
    pc = 32'hBFC0_0000;
    jumps = 0;
    model_reset();

    // Boot: 17 straight fetch cycles, narrow counter wraps to 1.
    do_reset(3);
    idle();
    idle();
    chk("boot_fetch_cnt_2", pf, 32'd2);
    repeat (15) idle();
    chk("fetch_wrap4", 32'(pf4), 32'd1);
    chk_counters("boot");

    // Load, store with halfword merge, reload.
    access(4'b0000, 32'h8000_0010, $urandom, 0);
    idle();
    chk_counters("load");
    access(4'b0011, 32'hA000_0020, 32'h1122_3344, 0);
    idle();
    access(4'b0000, 32'h8000_0020, $urandom, 0);
    idle();

    // Back-to-back load then store from a fresh reset.
    do_reset(2);
    idle();
    access(4'b0000, 32'h8000_0010, $urandom, 0);
    access(4'b1100, 32'h8000_0024, 32'h5566_7788, 0);
    idle();
    chk("b2b_data_cnt", pd, 32'd2);
    chk_counters("b2b");

    // Reset during the response of a store; the write must survive.
    access(4'b1111, 32'hA000_0030, 32'hCAFE_F00D, 1);
    idle();
    idle();
    access(4'b0000, 32'h8000_0030, $urandom, 0);
    idle();
    chk_counters("abort");

    // Randomized mix.
    jumps = 1;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40) idle();
      else if (r < 65) access(4'b0000, rand_daddr(), $urandom, 0);
      else if (r < 94) access(4'($urandom_range(1, 15)), rand_daddr(), $urandom, 0);
      else if (r < 97) access(4'($urandom_range(0, 15)), rand_daddr(), $urandom, 1);
      else do_reset(1 + $urandom_range(0, 2));
      chk_counters("rand");
    end

    idle();
    chk("q_issue_drained", 32'(q_issue.size()), 32'd0);
    chk("q_inst_drained", 32'(q_inst.size()), 32'd0);
    chk("q_data_drained", 32'(q_data.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_dmem_port_arbiter.md
Name: imem_dmem_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between the CPU's instruction-fetch port and its data port.
- Sits between the pipeline's inst/data SRAM interfaces and the physical memory.
- Data accesses take priority. The block produces the req_inst/req_data stall inputs the pipeline already consumes: req_data freezes E/M/W and F/D; req_inst freezes F/D and bubbles E.
- Fixed memory read latency is 1 cycle: address in cycle t, mem_rdata valid in t+1.
- Also keeps fetch, data and stall performance counters.

Parameters:
- ADDR_MASK, 32'h1FFF_FFFF, AND-mask applied to both CPU addresses to form mem_addr (kseg0/kseg1 unmapping).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- cpu_inst_addr  in  32  fetch address; the CPU fetches every cycle
- cpu_inst_rdata  out  32  fetched instruction
- cpu_data_en  in  1  data access request from M stage
- cpu_data_wen  in  4  byte write enables; 0 means load
- cpu_data_addr  in  32  data address
- cpu_data_wdata  in  32  store data
- cpu_data_rdata  out  32  load data
- req_inst  out  1  instruction not available this cycle
- req_data  out  1  data access not complete this cycle
- mem_en  out  1  memory enable
- mem_wen  out  4  memory byte write enables
- mem_addr  out  32  memory address, already masked with ADDR_MASK
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid one cycle after the address
- perf_fetch_cnt  out  CNT_W  number of fetches issued
- perf_data_cnt  out  CNT_W  number of data accesses issued
- perf_stall_cnt  out  CNT_W  number of stall cycles

Behaviour:
- Clock is clk; reset is resetn, synchronous, active-low. Both are already decided.
- State register has three states: S_BOOT, S_FETCH, S_DRESP. A prev_fetch flag records whether the previous cycle's port grant was a fetch.
- While resetn=0:
  - state goes to S_BOOT; prev_fetch, the instruction hold register and all counters clear to 0.
  - Outputs: mem_en=0, mem_wen=0, req_inst=1, req_data=0, cpu_inst_rdata=0, cpu_data_rdata=0.
- S_BOOT (first cycle after reset release):
  - Issue a fetch: mem_en=1, mem_wen=0, mem_addr = cpu_inst_addr & ADDR_MASK.
  - req_inst=1, req_data=0. Any cpu_data_en is ignored.
  - Next state S_FETCH.
- S_FETCH with cpu_data_en=0:
  - Issue a fetch as above. req_inst = ~prev_fetch, req_data=0. Stay in S_FETCH.
- S_FETCH with cpu_data_en=1 (data issue cycle):
  - Issue the data access: mem_en=1, mem_wen = cpu_data_wen, mem_addr = cpu_data_addr & ADDR_MASK, mem_wdata = cpu_data_wdata.
  - req_data=1 and req_inst = ~prev_fetch. cpu_inst_rdata still returns the fetch from the previous cycle.
  - Next state S_DRESP.
- S_DRESP (data response cycle):
  - cpu_data_rdata = mem_rdata, also for stores; the value is don't-care to the CPU.
  - req_data=0. req_inst=1 because no fetch was issued last cycle.
  - Issue a fetch of the held cpu_inst_addr. cpu_data_en is ignored, since it still shows the access being retired.
  - Next state S_FETCH.
- cpu_inst_rdata:
  - = mem_rdata when prev_fetch=1.
  - Otherwise = the hold register, which holds the last instruction delivered with prev_fetch=1.
- cpu_data_rdata holds its last S_DRESP value outside S_DRESP.
- Every data access, load or store, costs exactly 2 cycles: 1 cycle with req_data=1, then 1 cycle with req_inst=1.
- Back-to-back data accesses: a new cpu_data_en in the cycle after S_DRESP is issued immediately (prev_fetch=1, so req_inst=0).
- Counters:
  - perf_fetch_cnt +1 on each cycle a fetch is issued, including S_BOOT.
  - perf_data_cnt +1 on each data issue.
  - perf_stall_cnt +1 on each out-of-reset cycle with req_inst|req_data.
  - All counters wrap modulo 2^CNT_W with no saturation.
- Reset asserted mid-access (in S_DRESP or in a data issue cycle): the access is abandoned, no response is delivered, and the block returns to S_BOOT.
- A store write is committed by the memory in the issue cycle. Reset during S_DRESP does not undo it.

Test Plan:
- Reset release with cpu_data_en=0 and addresses 0xBFC00000, then 0xBFC00004:
  - cycle 0: mem_addr=0x1FC00000, req_inst=1.
  - cycle 1: req_inst=0, cpu_inst_rdata = mem word at 0x1FC00000.
  - perf_fetch_cnt=2 after 2 cycles.
- Load: cpu_data_en=1, wen=0, addr 0x80000010, memory holds 0xDEADBEEF at 0x10:
  - issue cycle: req_data=1, mem_addr=0x00000010, mem_wen=0.
  - next cycle: cpu_data_rdata=0xDEADBEEF, req_data=0, req_inst=1.
  - following cycle: req_inst=0.
  - perf_stall_cnt increases by 2.
- Store: wen=4'b0011, addr 0xA0000020, wdata 0x11223344:
  - mem_wen=4'b0011 for exactly one cycle.
  - a subsequent load of 0x20 returns the low halfword 0x3344 merged with the old data.
- Back-to-back: a load, then a store presented in the cycle after S_DRESP:
  - the second access is issued without an extra idle cycle.
  - perf_data_cnt=2 and total stall cycles = 4.
- Reset asserted during S_DRESP:
  - the next cycle shows S_BOOT behaviour (req_inst=1, mem_wen=0).
  - counters read 0.
- CNT_W=4 with 17 consecutive fetch cycles: perf_fetch_cnt wraps to 1.
